// File: rtl/alu_mdu.sv
// alu_mdu: single-cycle integer ALU plus an iterative multiply/divide unit.
// One request in flight at a time; results are presented as a one-cycle
// o_valid pulse with o_result held until the next completed operation.
module alu_mdu #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [4:0]      i_alu_op,
  input  logic [XLEN-1:0] i_operand_a,
  input  logic [XLEN-1:0] i_operand_b,
  input  logic            i_flush,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLL    = 5'd2;
  localparam logic [4:0] OP_SLT    = 5'd3;
  localparam logic [4:0] OP_SLTU   = 5'd4;
  localparam logic [4:0] OP_XOR    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_OR     = 5'd8;
  localparam logic [4:0] OP_AND    = 5'd9;
  localparam logic [4:0] OP_MUL    = 5'd10;
  localparam logic [4:0] OP_MULH   = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12;
  localparam logic [4:0] OP_MULHU  = 5'd13;
  localparam logic [4:0] OP_DIV    = 5'd14;
  localparam logic [4:0] OP_DIVU   = 5'd15;
  localparam logic [4:0] OP_REM    = 5'd16;
  localparam logic [4:0] OP_REMU   = 5'd17;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  // Architectural state
  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        op_q, op_d;
  logic              neg_q, neg_d;          // negate product / quotient at the end
  logic              rem_neg_q, rem_neg_d;  // negate remainder at the end
  // Shared iterative datapath: for multiply acc = {partial high, multiplier},
  // for divide acc = {partial remainder, dividend/quotient}.
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;        // multiplicand or divisor magnitude

  // Request decode
  logic              accept;
  logic [SHW-1:0]    shamt;
  logic              is_mul, is_div, div_signed, b_zero, div_ovf;
  logic              a_signed, b_signed, a_neg, b_neg, op_is_rem;
  logic [XLEN-1:0]   mag_a, mag_b, single_res;

  // Iteration step and final sign restoration
  logic [XLEN:0]     mul_sum, div_shift, div_trial;
  logic [2*XLEN-1:0] acc_step, prod_fix;
  logic [XLEN-1:0]   quo_step, rem_step, fin_res;

  assign o_ready  = (state_q != S_BUSY);
  assign o_valid  = (state_q == S_DONE);
  assign o_result = result_q;
  assign accept   = i_valid & o_ready & ~i_flush;
  assign shamt    = i_operand_b[SHW-1:0];

  // Decode the incoming request and its single-cycle result
  always_comb begin
    is_mul     = (i_alu_op >= OP_MUL) && (i_alu_op <= OP_MULHU);
    is_div     = (i_alu_op >= OP_DIV) && (i_alu_op <= OP_REMU);
    div_signed = (i_alu_op == OP_DIV) || (i_alu_op == OP_REM);
    op_is_rem  = (i_alu_op == OP_REM) || (i_alu_op == OP_REMU);
    b_zero     = (i_operand_b == '0);
    div_ovf    = div_signed && (i_operand_a == MOST_NEG) && (i_operand_b == '1);
    a_signed   = (i_alu_op == OP_MULH) || (i_alu_op == OP_MULHSU) || div_signed;
    b_signed   = (i_alu_op == OP_MULH) || div_signed;
    a_neg      = a_signed & i_operand_a[XLEN-1];
    b_neg      = b_signed & i_operand_b[XLEN-1];
    mag_a      = a_neg ? (-i_operand_a) : i_operand_a;
    mag_b      = b_neg ? (-i_operand_b) : i_operand_b;

    single_res = '0;
    case (i_alu_op)
      OP_ADD:  single_res = i_operand_a + i_operand_b;
      OP_SUB:  single_res = i_operand_a - i_operand_b;
      OP_SLL:  single_res = i_operand_a << shamt;
      OP_SLT:  single_res = {{(XLEN-1){1'b0}}, ($signed(i_operand_a) < $signed(i_operand_b))};
      OP_SLTU: single_res = {{(XLEN-1){1'b0}}, (i_operand_a < i_operand_b)};
      OP_XOR:  single_res = i_operand_a ^ i_operand_b;
      OP_SRL:  single_res = i_operand_a >> shamt;
      OP_SRA:  single_res = $unsigned($signed(i_operand_a) >>> shamt);
      OP_OR:   single_res = i_operand_a | i_operand_b;
      OP_AND:  single_res = i_operand_a & i_operand_b;
      // Only reached for divide-by-zero or signed overflow; a signed
      // overflow quotient equals A and its remainder is zero.
      OP_DIV, OP_DIVU: single_res = b_zero ? '1 : i_operand_a;
      OP_REM, OP_REMU: single_res = b_zero ? i_operand_a : '0;
      default: single_res = '0;
    endcase
  end

  // One shift-add or restoring-subtract step plus the sign-corrected result
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_trial = div_shift - {1'b0, opnd_q};
    if (op_q >= OP_DIV) begin
      if (div_trial[XLEN])
        acc_step = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      else
        acc_step = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    end

    prod_fix = neg_q ? (-acc_step) : acc_step;
    quo_step = acc_step[XLEN-1:0];
    rem_step = acc_step[2*XLEN-1:XLEN];

    fin_res = '0;
    case (op_q)
      OP_MUL:                       fin_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fin_res = neg_q ? (-quo_step) : quo_step;
      OP_REM, OP_REMU:              fin_res = rem_neg_q ? (-rem_step) : rem_step;
      default:                      fin_res = '0;
    endcase
  end

  // Next-state logic for the IDLE/BUSY/DONE controller and datapath
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    op_d      = op_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;

    case (state_q)
      S_BUSY: begin
        if (i_flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d  = S_DONE;
            result_d = fin_res;
          end
        end
      end
      default: begin
        // IDLE and DONE both accept; a flush or no request falls back to IDLE.
        state_d = S_IDLE;
        if (accept) begin
          if (is_mul || (is_div && !b_zero && !div_ovf)) begin
            state_d   = S_BUSY;
            cnt_d     = CW'(XLEN);
            op_d      = i_alu_op;
            neg_d     = a_neg ^ b_neg;
            rem_neg_d = a_neg;
            if (is_mul) begin
              acc_d  = {{XLEN{1'b0}}, mag_b};
              opnd_d = mag_a;
            end else begin
              acc_d  = {{XLEN{1'b0}}, mag_a};
              opnd_d = mag_b;
            end
          end else begin
            state_d  = S_DONE;
            result_d = single_res;
          end
        end
        // op_is_rem only matters for the sign flag chosen above
        if (accept && is_div && op_is_rem) rem_neg_d = a_neg;
      end
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      result_q  <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      acc_q     <= '0;
      opnd_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: randomized and directed checking of alu_mdu against an
// arithmetic reference model with latency tracking.
module tb_alu_mdu;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_valid = 1'b0;
  logic            o_ready;
  logic [4:0]      i_alu_op = '0;
  logic [XLEN-1:0] i_operand_a = '0;
  logic [XLEN-1:0] i_operand_b = '0;
  logic            i_flush = 1'b0;
  logic            o_valid;
  logic [XLEN-1:0] o_result;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  alu_mdu #(.XLEN(XLEN)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_alu_op    (i_alu_op),
    .i_operand_a (i_operand_a),
    .i_operand_b (i_operand_b),
    .i_flush     (i_flush),
    .o_valid     (o_valid),
    .o_result    (o_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at t=%0t", name, got, exp, $time);
  endtask

  // Reference arithmetic straight from the operation definitions
  function automatic logic [31:0] ref_res(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int         sa, sb;
    longint     la, lb, lua, lub;
    logic [63:0] p;
    sa  = a;
    sb  = b;
    la  = sa;
    lb  = sb;
    lua = longint'({32'd0, a});
    lub = longint'({32'd0, b});
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a << b[4:0];
      5'd3:  return (sa < sb) ? 32'd1 : 32'd0;
      5'd4:  return (a < b) ? 32'd1 : 32'd0;
      5'd5:  return a ^ b;
      5'd6:  return a >> b[4:0];
      5'd7:  return sa >>> b[4:0];
      5'd8:  return a | b;
      5'd9:  return a & b;
      5'd10: begin p = la * lb;   return p[31:0];  end
      5'd11: begin p = la * lb;   return p[63:32]; end
      5'd12: begin p = la * lub;  return p[63:32]; end
      5'd13: begin p = lua * lub; return p[63:32]; end
      5'd14: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        return sa / sb;
      end
      5'd15: return (b == 0) ? 32'hFFFFFFFF : a / b;
      5'd16: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        return sa % sb;
      end
      5'd17: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // Whether the request takes the XLEN-cycle iterative path
  function automatic bit ref_iter(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op >= 5'd10 && op <= 5'd13) return 1'b1;
    if (op >= 5'd14 && op <= 5'd17) begin
      if (b == 0) return 1'b0;
      if ((op == 5'd14 || op == 5'd16) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1'b0;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // Model: remaining busy cycles, expected pulse and held result
  int          m_left   = 0;
  bit          m_valid  = 1'b0;
  logic [31:0] m_result = '0;
  logic [31:0] m_pend   = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left   <= 0;
      m_valid  <= 1'b0;
      m_result <= '0;
    end else if (m_left > 0) begin
      m_valid <= 1'b0;
      if (i_flush) m_left <= 0;
      else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_valid  <= 1'b1;
          m_result <= m_pend;
        end
      end
    end else begin
      m_valid <= 1'b0;
      if (i_valid && !i_flush) begin
        if (ref_iter(i_alu_op, i_operand_a, i_operand_b)) begin
          m_left <= XLEN;
          m_pend <= ref_res(i_alu_op, i_operand_a, i_operand_b);
        end else begin
          m_valid  <= 1'b1;
          m_result <= ref_res(i_alu_op, i_operand_a, i_operand_b);
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("cyc_ready",  {63'd0, o_ready}, {63'd0, (m_left == 0)});
      check("cyc_valid",  {63'd0, o_valid}, {63'd0, m_valid});
      check("cyc_result", {32'd0, o_result}, {32'd0, m_result});
    end
  end

  // Issue one request at the current falling edge and wait for its result
  task automatic run_lit(input string name, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int k;
    i_valid = 1'b1;
    i_alu_op = op;
    i_operand_a = a;
    i_operand_b = b;
    @(negedge clk);
    i_valid = 1'b0;
    i_operand_a = $urandom();
    i_operand_b = $urandom();
    k = 1;
    while (!o_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    $display("txn %s op=%0d a=%h b=%h -> result=%h latency=%0d", name, op, a, b, o_result, k);
    check({name, "_result"}, {32'd0, o_result}, {32'd0, exp});
    check({name, "_latency"}, 64'(k), 64'(exp_lat));
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'd1;
      4: return $urandom_range(0, 20);
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int vcnt;
    // Pin the model against hand-computed values
    check("model_add",    {32'd0, ref_res(5'd0, 32'd5, 32'd7)}, 64'd12);
    check("model_slt",    {32'd0, ref_res(5'd3, 32'hFFFFFFFF, 32'd1)}, 64'd1);
    check("model_sltu",   {32'd0, ref_res(5'd4, 32'hFFFFFFFF, 32'd1)}, 64'd0);
    check("model_sra",    {32'd0, ref_res(5'd7, 32'h80000000, 32'd36)}, 64'hF8000000);
    check("model_mulhu",  {32'd0, ref_res(5'd13, 32'hFFFFFFFF, 32'd2)}, 64'd1);
    check("model_mul",    {32'd0, ref_res(5'd10, 32'hFFFFFFFF, 32'd2)}, 64'hFFFFFFFE);
    check("model_mulh",   {32'd0, ref_res(5'd11, 32'hFFFFFFFF, 32'hFFFFFFFF)}, 64'd0);
    check("model_div",    {32'd0, ref_res(5'd14, 32'hFFFFFFF9, 32'd2)}, 64'hFFFFFFFD);
    check("model_rem",    {32'd0, ref_res(5'd16, 32'hFFFFFFF9, 32'd2)}, 64'hFFFFFFFF);
    check("model_divu0",  {32'd0, ref_res(5'd15, 32'd9, 32'd0)}, 64'hFFFFFFFF);
    check("model_ovf",    {63'd0, ref_iter(5'd14, 32'h80000000, 32'hFFFFFFFF)}, 64'd0);

    // Reset state
    #12;
    check("rst_ready",  {63'd0, o_ready}, 64'd1);
    check("rst_valid",  {63'd0, o_valid}, 64'd0);
    check("rst_result", {32'd0, o_result}, 64'd0);

    // First accept on the first edge after release
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    run_lit("add",    5'd0,  32'd5,        32'd7,        32'd12,       1);
    run_lit("slt",    5'd3,  32'hFFFFFFFF, 32'd1,        32'd1,        1);
    run_lit("sltu",   5'd4,  32'hFFFFFFFF, 32'd1,        32'd0,        1);
    run_lit("sra",    5'd7,  32'h80000000, 32'd36,       32'hF8000000, 1);
    run_lit("mulhu",  5'd13, 32'hFFFFFFFF, 32'd2,        32'd1,        XLEN + 1);
    run_lit("mul",    5'd10, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, XLEN + 1);
    run_lit("mulh",   5'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        XLEN + 1);
    run_lit("div",    5'd14, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, XLEN + 1);
    run_lit("rem",    5'd16, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, XLEN + 1);
    run_lit("divu",   5'd15, 32'd100,      32'd7,        32'd14,       XLEN + 1);
    run_lit("remu",   5'd17, 32'd100,      32'd7,        32'd2,        XLEN + 1);
    run_lit("divu0",  5'd15, 32'd9,        32'd0,        32'hFFFFFFFF, 1);
    run_lit("remu0",  5'd17, 32'd9,        32'd0,        32'd9,        1);
    run_lit("divovf", 5'd14, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_lit("removf", 5'd16, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);
    run_lit("illegal",5'd25, 32'd3,        32'd4,        32'd0,        1);

    // Flush on the 10th busy cycle of a multiply
    i_valid = 1'b1; i_alu_op = 5'd10; i_operand_a = 32'd3; i_operand_b = 32'd3;
    @(negedge clk);
    i_valid = 1'b0;
    repeat (9) @(negedge clk);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    check("flush_ready", {63'd0, o_ready}, 64'd1);
    check("flush_valid", {63'd0, o_valid}, 64'd0);
    run_lit("after_flush", 5'd0, 32'd1, 32'd1, 32'd2, 1);

    // Asynchronous reset in the middle of a divide
    i_valid = 1'b1; i_alu_op = 5'd14; i_operand_a = 32'd1000; i_operand_b = 32'd3;
    @(negedge clk);
    i_valid = 1'b0;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid",  {63'd0, o_valid}, 64'd0);
    check("arst_ready",  {63'd0, o_ready}, 64'd1);
    check("arst_result", {32'd0, o_result}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    vcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (o_valid) vcnt++;
    end
    check("arst_no_spurious", 64'(vcnt), 64'd0);

    // Randomized traffic, including operand changes while busy
    for (int i = 0; i < 1500; i++) begin
      i_valid     = ($urandom_range(0, 99) < 60);
      i_alu_op    = ($urandom_range(0, 99) < 8) ? 5'($urandom_range(18, 31)) : 5'($urandom_range(0, 17));
      i_operand_a = rnd_opnd();
      i_operand_b = rnd_opnd();
      i_flush     = ($urandom_range(0, 99) < 3);
      @(negedge clk);
    end
    i_valid = 1'b0;
    i_flush = 1'b0;
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter: XLEN, 32, operand/result width; SHALL be legal for any even value 8..64.
REQ-002 Port: i_clk  input  1  rising-edge clock, sole clock.
REQ-003 Port: i_rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: i_valid  input  1  request strobe; accepted when i_valid & o_ready at a rising edge.
REQ-005 Port: o_ready  output  1  block can accept a request this cycle.
REQ-006 Port: i_alu_op  input  5  operation code, sampled on accept.
REQ-007 Port: i_operand_a  input  XLEN  operand A, sampled on accept.
REQ-008 Port: i_operand_b  input  XLEN  operand B, sampled on accept.
REQ-009 Port: i_flush  input  1  synchronous abort of the in-flight request.
REQ-010 Port: o_valid  output  1  one-cycle pulse, o_result valid.
REQ-011 Port: o_result  output  XLEN  registered result; holds last value between pulses.

Function
REQ-012 Op codes SHALL be: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU, 16 REM, 17 REMU; 18..31 illegal.
REQ-013 Shift amount SHALL be operand B bits [log2(XLEN)-1:0]; upper bits ignored.
REQ-014 SLT/SLTU SHALL return 1 or 0 zero-extended to XLEN; ADD/SUB SHALL wrap modulo 2^XLEN.
REQ-015 Ops 0..9 and illegal codes (result 0) SHALL be single-cycle: accept at edge E, o_valid=1 for the cycle after E.
REQ-016 MUL* SHALL use an iterative shift-add datapath, one partial product per cycle; MUL returns low XLEN bits, MULH/MULHSU/MULHU the high XLEN bits of the 2*XLEN signed*signed / signed*unsigned / unsigned*unsigned product.
REQ-017 DIV*/REM* SHALL use an iterative restoring divider on magnitudes, one quotient bit per cycle, signs restored at completion; quotient rounds toward zero, remainder takes dividend sign.
REQ-018 Iterative ops SHALL have latency exactly XLEN: accept at edge E, o_valid=1 for the cycle after edge E+XLEN.
REQ-019 Divide by zero SHALL complete single-cycle: DIV/DIVU = all ones, REM/REMU = operand A.
REQ-020 Signed overflow (A = most-negative, B = -1) SHALL complete single-cycle: DIV = A, REM = 0.
REQ-021 State machine SHALL be IDLE, BUSY, DONE: IDLE->DONE on accept of single-cycle op; IDLE->BUSY on accept of iterative op; BUSY->DONE after XLEN steps; DONE->IDLE without accept; DONE->DONE/BUSY on a new accept.
REQ-022 o_ready SHALL be 1 in IDLE and DONE, 0 in BUSY; back-to-back accepts every cycle SHALL be supported for single-cycle ops.
REQ-023 o_valid SHALL be 1 only in DONE; no backpressure on results.
REQ-024 i_valid while o_ready=0 SHALL be ignored with no state change.
REQ-025 i_flush in BUSY SHALL return to IDLE at the next edge with no o_valid; o_result unchanged; i_flush in IDLE/DONE SHALL suppress any accept that cycle and go to IDLE.
REQ-026 Operand changes after accept SHALL not affect the in-flight result.

Reset
REQ-027 i_rst_n=0 SHALL immediately force IDLE, o_valid=0, o_result=0, o_ready=1, iteration counter 0, independent of i_clk.
REQ-028 Reset during BUSY SHALL discard the operation; no o_valid after reset release until a new accept.
REQ-029 First accept SHALL be possible at the first rising edge with i_rst_n=1.

Verification (XLEN=32)
REQ-030 ADD 5,7 accepted -> next cycle o_valid=1, o_result=12; SLT 0xFFFFFFFF,1 -> 1; SLTU same -> 0; SRA 0x80000000,36 -> 0xF8000000.
REQ-031 MULHU 0xFFFFFFFF,2 -> o_ready=0 32 cycles, then o_valid=1, o_result=1; MUL same -> 0xFFFFFFFE; MULH 0xFFFFFFFF,0xFFFFFFFF -> 0.
REQ-032 DIV -7,2 -> 0xFFFFFFFD after 32 cycles; REM -7,2 -> 0xFFFFFFFF; DIVU 100,7 -> 14; REMU -> 2.
REQ-033 DIVU 9,0 -> next cycle 0xFFFFFFFF; REMU 9,0 -> 9; DIV 0x80000000,0xFFFFFFFF -> 0x80000000; REM -> 0.
REQ-034 MUL accepted, i_flush at 10th BUSY cycle -> no o_valid, o_ready=1 next cycle, ADD 1,1 then accepted -> 2.
REQ-035 i_rst_n low mid-DIV -> o_valid=0, o_result=0, o_ready=1 asynchronously; no spurious o_valid after release.
